// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, synchronises the
// rows, and holds the column while a key is down so key_code stays stable.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       cols_n_q, cols_n_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_pressed_q, key_pressed_d;
  logic [3:0]       sync1_q, sync2_q;
  logic             tick_c;

  // Lowest-index active row wins when several keys share the column.
  function automatic logic [1:0] low_zero(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: return 4'h1;
      4'b00_01: return 4'h2;
      4'b00_10: return 4'h3;
      4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;
      4'b01_01: return 4'h5;
      4'b01_10: return 4'h6;
      4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;
      4'b10_01: return 4'h8;
      4'b10_10: return 4'h9;
      4'b10_11: return 4'hC;
      4'b11_00: return 4'hE;
      4'b11_01: return 4'h0;
      4'b11_10: return 4'hF;
      default:  return 4'hD;
    endcase
  endfunction

  assign tick_c = (div_q == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    div_d         = tick_c ? '0 : div_q + DIV_W'(1);

    if (tick_c) begin
      case (state_q)
        SCAN: begin
          if (sync2_q != 4'hF) begin
            key_code_d    = key_map(low_zero(sync2_q), col_q);
            key_pressed_d = 1'b1;
            state_d       = HOLD;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        HOLD: begin
          // Only a fully released column ends the hold; extra keys are ignored.
          if (sync2_q == 4'hF) begin
            key_pressed_d = 1'b0;
            col_d         = col_q + 2'd1;
            state_d       = SCAN;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    cols_n_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SCAN;
      col_q         <= 2'd0;
      cols_n_q      <= 4'b1110;
      div_q         <= '0;
      key_code_q    <= 4'h0;
      key_pressed_q <= 1'b0;
      sync1_q       <= 4'hF;
      sync2_q       <= 4'hF;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      cols_n_q      <= cols_n_d;
      div_q         <= div_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      sync1_q       <= rows_n;
      sync2_q       <= sync1_q;
    end
  end

  assign cols_n      = cols_n_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4 and a passive matrix keypad model.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic [15:0] pressed;  // bit r*4+c = key at row r, column c held down

  int n_checks;
  int n_pass;
  int n;  // posedges since the most recent reset release

  keypad_scanner #(.SCAN_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .rows_n      (rows_n),
    .cols_n      (cols_n),
    .key_code    (key_code),
    .key_pressed (key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A row reads low only through a pressed key on a driven column.
  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t n=%0d)", tag, got, exp, $time, n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic wait_kp(input logic lvl, input int budget);
    int k;
    k = 0;
    while (key_pressed !== lvl && k < budget) begin
      step();
      k++;
    end
    check("kp_wait", 32'(key_pressed), 32'(lvl));
  endtask

  task automatic press_release(input int r, input int c, input logic [3:0] exp);
    pressed[r*4+c] = 1'b1;
    wait_kp(1'b1, 40);
    check("s5_code", 32'(key_code), 32'(exp));
    check("s5_cols", 32'(cols_n), 32'(col_pat(c)));
    pressed = '0;
    wait_kp(1'b0, 40);
    check("s5_code_kept", 32'(key_code), 32'(exp));
  endtask

  typedef struct { int r; int c; logic [3:0] code; } key_vec_t;
  key_vec_t corner [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    n        = 0;
    pressed  = '0;
    reset    = 1'b1;
    corner[0] = '{3, 1, 4'h0};
    corner[1] = '{3, 3, 4'hD};
    corner[2] = '{3, 0, 4'hE};
    corner[3] = '{0, 3, 4'hA};
    corner[4] = '{2, 2, 4'h9};
    corner[5] = '{1, 3, 4'hB};
    corner[6] = '{2, 3, 4'hC};
    corner[7] = '{3, 2, 4'hF};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    n     = 0;
    check("rst_cols", 32'(cols_n), 32'h0000_000E);
    check("rst_kp",   32'(key_pressed), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);

    // 1: idle column walk, one step every 4 cycles
    for (int i = 1; i <= 20; i++) begin
      step();
      check("s1_cols", 32'(cols_n), 32'(col_pat((n / 4) % 4)));
      check("s1_kp",   32'(key_pressed), 32'h0);
      check("s1_code", 32'(key_code), 32'h0);
    end

    // 2: key 6 pressed while column 1 is driven; detected on the col2 tick (edge 28)
    pressed[1*4+2] = 1'b1;
    run_to(27);
    check("s2_kp_pre", 32'(key_pressed), 32'h0);
    step();
    check("s2_kp",   32'(key_pressed), 32'h1);
    check("s2_code", 32'(key_code), 32'h6);
    check("s2_cols", 32'(cols_n), 32'hB);
    while (n < 40) begin
      step();
      check("s2_hold_cols", 32'(cols_n), 32'hB);
      check("s2_hold_kp",   32'(key_pressed), 32'h1);
    end

    // 3: release; drop seen at the tick on edge 44
    pressed = '0;
    run_to(43);
    check("s3_kp_pre", 32'(key_pressed), 32'h1);
    step();
    check("s3_kp",   32'(key_pressed), 32'h0);
    check("s3_cols", 32'(cols_n), 32'h7);
    check("s3_code", 32'(key_code), 32'h6);
    run_to(47);
    check("s3_cols47", 32'(cols_n), 32'h7);
    step();
    check("s3_cols48", 32'(cols_n), 32'hE);

    // 4: rows 0 and 3 in column 2 -> row 0 wins (key 3); extra keys do not disturb
    pressed[0*4+2] = 1'b1;
    pressed[3*4+2] = 1'b1;
    run_to(59);
    check("s4_kp_pre", 32'(key_pressed), 32'h0);
    step();
    check("s4_kp",   32'(key_pressed), 32'h1);
    check("s4_code", 32'(key_code), 32'h3);
    check("s4_cols", 32'(cols_n), 32'hB);
    step();
    pressed[2*4+0] = 1'b1;
    while (n < 72) begin
      step();
      check("s4_extra_code", 32'(key_code), 32'h3);
      check("s4_extra_kp",   32'(key_pressed), 32'h1);
      check("s4_extra_cols", 32'(cols_n), 32'hB);
    end
    pressed[0*4+2] = 1'b0;
    while (n < 80) begin
      step();
      check("s4_partial_code", 32'(key_code), 32'h3);
      check("s4_partial_kp",   32'(key_pressed), 32'h1);
    end
    pressed = '0;
    run_to(83);
    check("s4_kp_pre_rel", 32'(key_pressed), 32'h1);
    step();
    check("s4_kp_rel",   32'(key_pressed), 32'h0);
    check("s4_cols_rel", 32'(cols_n), 32'h7);
    check("s4_code_rel", 32'(key_code), 32'h3);

    // 5: corner and remaining edge-column keys
    foreach (corner[i]) press_release(corner[i].r, corner[i].c, corner[i].code);

    // 6: asynchronous reset while holding key 9, then re-detection in the col2 window
    pressed[2*4+2] = 1'b1;
    wait_kp(1'b1, 40);
    check("s6_code_pre", 32'(key_code), 32'h9);
    step();
    #3;
    reset = 1'b1;
    #1;
    check("s6_rst_cols", 32'(cols_n), 32'hE);
    check("s6_rst_kp",   32'(key_pressed), 32'h0);
    check("s6_rst_code", 32'(key_code), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    check("s6_cols0", 32'(cols_n), 32'hE);
    run_to(11);
    check("s6_kp_pre",   32'(key_pressed), 32'h0);
    check("s6_cols_pre", 32'(cols_n), 32'hB);
    step();
    check("s6_kp",   32'(key_pressed), 32'h1);
    check("s6_code", 32'(key_code), 32'h9);
    check("s6_cols", 32'(cols_n), 32'hB);
    pressed = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
